mem_wb_stage: RTL and testbench

Writeback stage of the 5-stage RISC-V pipeline. It registers the MEM-stage result (MEM/WB pipeline register), extracts and extends load data by size and byte offset, selects the writeback source, and drives the register file write port. It also publishes the writeback value for ID-stage bypassing and keeps a 64-bit retired-instruction counter.

---
 rtl/mem_wb_stage.sv | 108 ++++++++++
 tb/tb_mem_wb_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mem_wb_stage.sv
// MEM/WB pipeline register and writeback: load extraction, source select, regfile write port,
// sticky misaligned-load flag and 64-bit retired-instruction counter.
module mem_wb_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        stall,
  input  logic        flush,
  input  logic        m_valid,
  input  logic        m_reg_write,
  input  logic [4:0]  m_rd,
  input  logic [1:0]  m_wb_sel,
  input  logic [2:0]  m_funct3,
  input  logic [31:0] m_alu_result,
  input  logic [31:0] m_pc_plus4,
  input  logic [31:0] m_load_data,
  output logic        rf_we,
  output logic [4:0]  rf_wa,
  output logic [31:0] rf_wd,
  output logic        wb_valid,
  output logic        misalign_err,
  output logic [63:0] instret
);

  logic        valid_q;
  logic        reg_write_q;
  logic [4:0]  rd_q;
  logic [1:0]  wb_sel_q;
  logic [2:0]  funct3_q;
  logic [31:0] alu_q;
  logic [31:0] pc4_q;
  logic [31:0] ld_q;
  logic        err_q;
  logic [63:0] instret_q;

  logic [1:0]  off;
  logic [7:0]  byte_val;
  logic [15:0] half_val;
  logic [31:0] load_val;
  logic        misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q     <= 1'b0;
      reg_write_q <= 1'b0;
      rd_q        <= 5'd0;
      wb_sel_q    <= 2'd0;
      funct3_q    <= 3'd0;
      alu_q       <= 32'd0;
      pc4_q       <= 32'd0;
      ld_q        <= 32'd0;
      err_q       <= 1'b0;
      instret_q   <= 64'd0;
    end else begin
      // An entry retires when it leaves WB: released from stall, or flushed out from under one.
      if (valid_q && (!stall || flush))
        instret_q <= instret_q + 64'd1;
      if (valid_q && misaligned)
        err_q <= 1'b1;
      if (flush) begin
        valid_q     <= 1'b0;
        reg_write_q <= 1'b0;
      end else if (!stall) begin
        valid_q     <= m_valid;
        reg_write_q <= m_reg_write;
        rd_q        <= m_rd;
        wb_sel_q    <= m_wb_sel;
        funct3_q    <= m_funct3;
        alu_q       <= m_alu_result;
        pc4_q       <= m_pc_plus4;
        ld_q        <= m_load_data;
      end
    end
  end

  always_comb begin
    off = alu_q[1:0];
    case (off)
      2'd0:    byte_val = ld_q[7:0];
      2'd1:    byte_val = ld_q[15:8];
      2'd2:    byte_val = ld_q[23:16];
      default: byte_val = ld_q[31:24];
    endcase
    half_val = off[1] ? ld_q[31:16] : ld_q[15:0];
    case (funct3_q)
      3'b000:  load_val = {{24{byte_val[7]}}, byte_val};
      3'b100:  load_val = {24'd0, byte_val};
      3'b001:  load_val = {{16{half_val[15]}}, half_val};
      3'b101:  load_val = {16'd0, half_val};
      default: load_val = ld_q;
    endcase
    misaligned = (wb_sel_q == 2'b01) &&
                 ((((funct3_q == 3'b001) || (funct3_q == 3'b101)) && off[0]) ||
                  ((funct3_q == 3'b010) && (off != 2'd0)));
    case (wb_sel_q)
      2'b01:   rf_wd = load_val;
      2'b10:   rf_wd = pc4_q;
      default: rf_wd = alu_q;
    endcase
  end

  assign rf_we        = valid_q && reg_write_q && (rd_q != 5'd0) && !misaligned;
  assign rf_wa        = rd_q;
  assign wb_valid     = valid_q;
  // The flag is visible while the offending load sits in WB, then held by err_q.
  assign misalign_err = err_q || (valid_q && misaligned);
  assign instret      = instret_q;

endmodule

// File: tb/tb_mem_wb_stage.sv
// Randomized and directed bench for mem_wb_stage against a behavioural writeback model.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, flush, m_valid, m_reg_write;
  logic [4:0]  m_rd;
  logic [1:0]  m_wb_sel;
  logic [2:0]  m_funct3;
  logic [31:0] m_alu_result, m_pc_plus4, m_load_data;
  logic        rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;
  logic        wb_valid, misalign_err;
  logic [63:0] instret;

  int n_cmp = 0;
  int n_err = 0;

  // Model of the instruction currently in WB.
  logic        e_valid, e_rw;
  logic [4:0]  e_rd;
  logic [1:0]  e_sel;
  logic [2:0]  e_f3;
  logic [31:0] e_alu, e_pc4, e_ld;
  logic        e_sticky;
  logic [63:0] e_cnt;

  mem_wb_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
    .m_valid(m_valid), .m_reg_write(m_reg_write), .m_rd(m_rd), .m_wb_sel(m_wb_sel),
    .m_funct3(m_funct3), .m_alu_result(m_alu_result), .m_pc_plus4(m_pc_plus4),
    .m_load_data(m_load_data), .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd),
    .wb_valid(wb_valid), .misalign_err(misalign_err), .instret(instret)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic exp_mis();
    int o;
    o = int'(e_alu % 4);
    if (e_sel != 2'd1) return 1'b0;
    if ((e_f3 == 3'd1 || e_f3 == 3'd5) && (o % 2 == 1)) return 1'b1;
    if (e_f3 == 3'd2 && o != 0) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic [31:0] exp_wd();
    logic [31:0] b, h;
    int o;
    o = int'(e_alu % 4);
    b = (e_ld >> (8 * o)) & 32'hFF;
    h = (e_ld >> (16 * (o / 2))) & 32'hFFFF;
    if (e_sel == 2'd2) return e_pc4;
    if (e_sel != 2'd1) return e_alu;
    case (e_f3)
      3'd0:    return (b >= 32'd128) ? b - 32'd256 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32'd32768) ? h - 32'd65536 : h;
      3'd5:    return h;
      default: return e_ld;
    endcase
  endfunction

  task automatic model_reset();
    e_valid = 0; e_rw = 0; e_rd = 0; e_sel = 0; e_f3 = 0;
    e_alu = 0; e_pc4 = 0; e_ld = 0; e_sticky = 0; e_cnt = 0;
  endtask

  task automatic check_all(input string tag);
    logic exp_we;
    exp_we = e_valid && e_rw && (e_rd != 0) && !exp_mis();
    check({tag, ".we"}, {63'd0, rf_we}, {63'd0, exp_we});
    check({tag, ".valid"}, {63'd0, wb_valid}, {63'd0, e_valid});
    check({tag, ".merr"}, {63'd0, misalign_err}, {63'd0, e_sticky | (e_valid & exp_mis())});
    check({tag, ".instret"}, instret, e_cnt);
    if (e_valid) begin
      check({tag, ".wa"}, {59'd0, rf_wa}, {59'd0, e_rd});
      check({tag, ".wd"}, {32'd0, rf_wd}, {32'd0, exp_wd()});
    end
  endtask

  // One clock: update model at the rising edge, then sample at the falling edge.
  task automatic cycle();
    @(posedge clk);
    if (!rst_n) model_reset();
    else begin
      if (e_valid && (!stall || flush)) e_cnt = e_cnt + 1;
      if (e_valid && exp_mis()) e_sticky = 1;
      if (flush) begin
        e_valid = 0; e_rw = 0;
      end else if (!stall) begin
        e_valid = m_valid; e_rw = m_reg_write; e_rd = m_rd; e_sel = m_wb_sel;
        e_f3 = m_funct3; e_alu = m_alu_result; e_pc4 = m_pc_plus4; e_ld = m_load_data;
      end
    end
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic rw, input logic [4:0] rd, input logic [1:0] sel,
                       input logic [2:0] f3, input logic [31:0] alu, input logic [31:0] pc4,
                       input logic [31:0] ld, input logic st, input logic fl);
    m_valid = v; m_reg_write = rw; m_rd = rd; m_wb_sel = sel; m_funct3 = f3;
    m_alu_result = alu; m_pc_plus4 = pc4; m_load_data = ld; stall = st; flush = fl;
    cycle();
    check_all("model");
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".we"}, {63'd0, rf_we}, 64'd0);
    check({tag, ".wa"}, {59'd0, rf_wa}, 64'd0);
    check({tag, ".wd"}, {32'd0, rf_wd}, 64'd0);
    check({tag, ".valid"}, {63'd0, wb_valid}, 64'd0);
    check({tag, ".merr"}, {63'd0, misalign_err}, 64'd0);
    check({tag, ".instret"}, instret, 64'd0);
  endtask

  initial begin
    model_reset();
    rst_n = 0; stall = 0; flush = 0; m_valid = 0; m_reg_write = 0; m_rd = 0;
    m_wb_sel = 0; m_funct3 = 0; m_alu_result = 0; m_pc_plus4 = 0; m_load_data = 0;
    #12;
    check_zero("reset");
    @(negedge clk);
    rst_n = 1;

    drive(1, 1, 5'd5, 2'b00, 3'd0, 32'h1234_5678, 32'h0, 32'h0, 0, 0);
    check("alu.wd", {32'd0, rf_wd}, 64'h1234_5678);
    check("alu.we", {63'd0, rf_we}, 64'd1);
    drive(0, 0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0);
    check("alu.instret", instret, 64'd1);

    drive(1, 1, 5'd3, 2'b01, 3'b000, 32'h2003, 32'h0, 32'h80FF_7F01, 0, 0);
    check("lb", {32'd0, rf_wd}, 64'hFFFF_FF80);
    drive(1, 1, 5'd3, 2'b01, 3'b100, 32'h2003, 32'h0, 32'h80FF_7F01, 0, 0);
    check("lbu", {32'd0, rf_wd}, 64'h0000_0080);
    drive(1, 1, 5'd3, 2'b01, 3'b001, 32'h2002, 32'h0, 32'h80FF_7F01, 0, 0);
    check("lh", {32'd0, rf_wd}, 64'hFFFF_80FF);
    drive(1, 1, 5'd3, 2'b01, 3'b101, 32'h2000, 32'h0, 32'h80FF_7F01, 0, 0);
    check("lhu", {32'd0, rf_wd}, 64'h0000_7F01);
    drive(1, 1, 5'd3, 2'b01, 3'b010, 32'h2000, 32'h0, 32'h80FF_7F01, 0, 0);
    check("lw", {32'd0, rf_wd}, 64'h80FF_7F01);

    drive(1, 1, 5'd0, 2'b00, 3'd0, 32'hDEAD_BEEF, 32'h0, 32'h0, 0, 0);
    check("x0.we", {63'd0, rf_we}, 64'd0);
    drive(1, 1, 5'd1, 2'b10, 3'd0, 32'h5555_0000, 32'h0000_0104, 32'h0, 0, 0);
    check("jal.wd", {32'd0, rf_wd}, 64'h0000_0104);

    drive(1, 1, 5'd9, 2'b00, 3'd0, 32'hCAFE_0009, 32'h0, 32'h0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 5'd4, 2'b10, 3'd0, $urandom, $urandom, $urandom, 1, 0);
      check("stall.wd", {32'd0, rf_wd}, 64'hCAFE_0009);
      check("stall.we", {63'd0, rf_we}, 64'd1);
    end
    drive(0, 0, 5'd0, 2'b00, 3'd0, 32'h0, 32'h0, 32'h0, 0, 0);
    drive(1, 1, 5'd6, 2'b00, 3'd0, 32'h0000_0066, 32'h0, 32'h0, 0, 0);
    drive(1, 1, 5'd7, 2'b00, 3'd0, 32'h0000_0077, 32'h0, 32'h0, 1, 1);
    check("stflush.valid", {63'd0, wb_valid}, 64'd0);
    check("stflush.we", {63'd0, rf_we}, 64'd0);

    drive(1, 1, 5'd8, 2'b00, 3'd0, 32'h0000_0088, 32'h0, 32'h0, 0, 0);
    #2 rst_n = 0;
    #1 check_zero("midreset");
    model_reset();
    @(negedge clk);
    m_valid = 0; rst_n = 1;

    drive(1, 1, 5'd2, 2'b00, 3'd0, 32'h0000_0022, 32'h0, 32'h0, 0, 0);
    check("premis.merr", {63'd0, misalign_err}, 64'd0);
    drive(1, 1, 5'd7, 2'b01, 3'b010, 32'h0000_1002, 32'h0, 32'h1111_2222, 0, 0);
    check("mis.we", {63'd0, rf_we}, 64'd0);
    check("mis.merr", {63'd0, misalign_err}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      drive(1, 1, 5'(i + 10), 2'b00, 3'd0, $urandom, 32'h0, 32'h0, 0, 0);
      check("mis.hold", {63'd0, misalign_err}, 64'd1);
    end

    for (int i = 0; i < 600; i++)
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, 5'($urandom),
            2'($urandom), 3'($urandom), $urandom, $urandom, $urandom,
            $urandom_range(0, 4) == 0, $urandom_range(0, 9) == 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
